// File: rtl/control_pipe_unit.sv
// Decode of op/fn3/fn7[5] plus E/M/W control registers; optional illegal trap under CTRL_ILLEGAL_TRAP_EN.
// imm_src_d/illegal_d combinational, D->E->M->W one cycle each; stall_e holds E and bubbles M, flush_e bubbles E.
module control_pipe_unit #(
  parameter int ALU_CTRL_W   = 4,
  parameter int IMM_SRC_W    = 3,
  parameter int RESULT_SRC_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              op_d,
  input  logic [2:0]              fn3_d,
  input  logic                    fn7_5_d,
  input  logic                    valid_d,
  input  logic                    stall_e,
  input  logic                    flush_e,
  output logic [IMM_SRC_W-1:0]    imm_src_d,
  output logic                    illegal_d,
  output logic                    valid_e,
  output logic [ALU_CTRL_W-1:0]   alu_control_e,
  output logic                    alu_src_e,
  output logic                    branch_e,
  output logic                    jump_e,
  output logic [2:0]              branch_fn3_e,
  output logic                    valid_m,
  output logic                    mem_write_m,
  output logic [RESULT_SRC_W-1:0] result_src_m,
  output logic                    reg_write_m,
  output logic                    valid_w,
  output logic [RESULT_SRC_W-1:0] result_src_w,
  output logic                    reg_write_w
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                    illegal_e,
  output logic                    trap_sticky
`endif
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                         ALU_SRA = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

  logic       reg_write_dec, alu_src_dec, mem_write_dec, branch_dec, jump_dec;
  logic [2:0] imm3;
  logic [1:0] res2, alu_op;
  logic [3:0] alu4;

  always_comb begin
    reg_write_dec = 1'b0;
    imm3          = 3'b000;
    alu_src_dec   = 1'b0;
    mem_write_dec = 1'b0;
    res2          = 2'b00;
    branch_dec    = 1'b0;
    jump_dec      = 1'b0;
    alu_op        = 2'b00;
    illegal_d     = 1'b0;
    case (op_d)
      7'b0000011: begin reg_write_dec = 1'b1; alu_src_dec = 1'b1; res2 = 2'b01; end
      7'b0100011: begin imm3 = 3'b001; alu_src_dec = 1'b1; mem_write_dec = 1'b1; end
      7'b0110011: begin reg_write_dec = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write_dec = 1'b1; alu_src_dec = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm3 = 3'b010; branch_dec = 1'b1; alu_op = 2'b01; end
      7'b1101111: begin reg_write_dec = 1'b1; imm3 = 3'b011; res2 = 2'b10; jump_dec = 1'b1; end
      7'b0110111: begin reg_write_dec = 1'b1; imm3 = 3'b100; alu_src_dec = 1'b1; alu_op = 2'b11; end
      default:    illegal_d = 1'b1;
    endcase
  end

  assign imm_src_d = IMM_SRC_W'(imm3);

  // Only register-register add becomes sub on fn7[5]; addi ignores that bit.
  always_comb begin
    alu4 = ALU_ADD;
    case (alu_op)
      2'b00: alu4 = ALU_ADD;
      2'b01: alu4 = ALU_SUB;
      2'b11: alu4 = ALU_PASSB;
      default: begin
        case (fn3_d)
          3'b000:  alu4 = (op_d == 7'b0110011 && fn7_5_d) ? ALU_SUB : ALU_ADD;
          3'b001:  alu4 = ALU_SLL;
          3'b010:  alu4 = ALU_SLT;
          3'b011:  alu4 = ALU_SLTU;
          3'b100:  alu4 = ALU_XOR;
          3'b101:  alu4 = fn7_5_d ? ALU_SRA : ALU_SRL;
          3'b110:  alu4 = ALU_OR;
          default: alu4 = ALU_AND;
        endcase
      end
    endcase
  end

  logic                    e_valid_n, e_alu_src_n, e_branch_n, e_jump_n, e_mem_write_n, e_reg_write_n;
  logic [ALU_CTRL_W-1:0]   e_alu_n;
  logic [2:0]              e_fn3_n;
  logic [RESULT_SRC_W-1:0] e_res_n;
  logic                    mem_write_e, reg_write_e;
  logic [RESULT_SRC_W-1:0] result_src_e;

  // An empty D slot or an illegal opcode yields zero control fields.
  always_comb begin
    e_valid_n     = valid_d;
    e_alu_n       = '0;
    e_alu_src_n   = 1'b0;
    e_branch_n    = 1'b0;
    e_jump_n      = 1'b0;
    e_fn3_n       = 3'b000;
    e_mem_write_n = 1'b0;
    e_res_n       = '0;
    e_reg_write_n = 1'b0;
    if (valid_d && !illegal_d) begin
      e_alu_n       = ALU_CTRL_W'(alu4);
      e_alu_src_n   = alu_src_dec;
      e_branch_n    = branch_dec;
      e_jump_n      = jump_dec;
      e_fn3_n       = fn3_d;
      e_mem_write_n = mem_write_dec;
      e_res_n       = RESULT_SRC_W'(res2);
      e_reg_write_n = reg_write_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      valid_e       <= 1'b0;
      alu_control_e <= '0;
      alu_src_e     <= 1'b0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
      branch_fn3_e  <= 3'b000;
      mem_write_e   <= 1'b0;
      result_src_e  <= '0;
      reg_write_e   <= 1'b0;
    end else if (!stall_e) begin
      valid_e       <= e_valid_n;
      alu_control_e <= e_alu_n;
      alu_src_e     <= e_alu_src_n;
      branch_e      <= e_branch_n;
      jump_e        <= e_jump_n;
      branch_fn3_e  <= e_fn3_n;
      mem_write_e   <= e_mem_write_n;
      result_src_e  <= e_res_n;
      reg_write_e   <= e_reg_write_n;
    end
  end

  logic squash_m;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign squash_m = illegal_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_e   <= 1'b0;
      trap_sticky <= 1'b0;
    end else begin
      if (flush_e)       illegal_e <= 1'b0;
      else if (!stall_e) illegal_e <= valid_d && illegal_d;
      if (valid_e && illegal_e) trap_sticky <= 1'b1;
    end
  end
`else
  assign squash_m = 1'b0;
`endif

  // A held E must not be duplicated into M, so M takes a bubble while stalled.
  always_ff @(posedge clk) begin
    if (rst || (stall_e && !flush_e)) begin
      valid_m      <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      reg_write_m  <= 1'b0;
    end else begin
      valid_m      <= valid_e && !squash_m;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      reg_write_m  <= reg_write_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w      <= 1'b0;
      result_src_w <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      valid_w      <= valid_m;
      result_src_w <= result_src_m;
      reg_write_w  <= reg_write_m;
    end
  end

endmodule

// File: tb/tb_control_pipe_unit.sv
// Table-driven bench for control_pipe_unit with a stage-expectation scoreboard.
module tb_control_pipe_unit;

  logic       clk = 1'b0;
  logic       rst, fn7_5_d, valid_d, stall_e, flush_e;
  logic [6:0] op_d;
  logic [2:0] fn3_d;
  logic [2:0] imm_src_d;
  logic       illegal_d, valid_e, alu_src_e, branch_e, jump_e;
  logic [3:0] alu_control_e;
  logic [2:0] branch_fn3_e;
  logic       valid_m, mem_write_m, reg_write_m, valid_w, reg_write_w;
  logic [1:0] result_src_m, result_src_w;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_e, trap_sticky;
`endif

  control_pipe_unit dut (
    .clk(clk), .rst(rst), .op_d(op_d), .fn3_d(fn3_d), .fn7_5_d(fn7_5_d),
    .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_src_d(imm_src_d), .illegal_d(illegal_d), .valid_e(valid_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
    .jump_e(jump_e), .branch_fn3_e(branch_fn3_e), .valid_m(valid_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .reg_write_m(reg_write_m),
    .valid_w(valid_w), .result_src_w(result_src_w), .reg_write_w(reg_write_w)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_e(illegal_e), .trap_sticky(trap_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op; logic [2:0] fn3; logic f7; logic vld;
    logic [2:0] imm; logic ill; logic [3:0] alu;
    logic asrc, br, jmp, mw; logic [1:0] res; logic rw;
  } vec_t;

  typedef struct packed {
    logic v; logic ill; logic [3:0] alu; logic asrc, br, jmp;
    logic [2:0] bf; logic mw; logic [1:0] res; logic rw;
  } st_t;

  int   checks = 0;
  int   failures = 0;
  st_t  sb[$];
  st_t  pe = '0, pm = '0, pw = '0;
  logic trap = 1'b0;
  vec_t tbl[19];
  vec_t v_add, v_lw, v_sw, v_beq, v_jal, v_nop;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] fn3, input logic f7,
                              input logic vld, input logic [2:0] imm, input logic ill,
                              input logic [3:0] alu, input logic asrc, input logic br,
                              input logic jmp, input logic mw, input logic [1:0] res,
                              input logic rw);
    vec_t v;
    v.op = op; v.fn3 = fn3; v.f7 = f7; v.vld = vld; v.imm = imm; v.ill = ill;
    v.alu = alu; v.asrc = asrc; v.br = br; v.jmp = jmp; v.mw = mw; v.res = res; v.rw = rw;
    return v;
  endfunction

  function automatic st_t to_stage(input vec_t v);
    st_t s = '0;
    if (v.vld) begin
      s.v = 1'b1;
      s.ill = v.ill;
      if (!v.ill) begin
        s.alu = v.alu; s.asrc = v.asrc; s.br = v.br; s.jmp = v.jmp;
        s.bf = v.fn3; s.mw = v.mw; s.res = v.res; s.rw = v.rw;
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One D-stage cycle: drive, check decode, clock, advance the expectation model, check stages.
  task automatic step(input vec_t v, input logic st, input logic fl, input logic r);
    st_t popped;
    op_d = v.op; fn3_d = v.fn3; fn7_5_d = v.f7; valid_d = v.vld;
    stall_e = st; flush_e = fl; rst = r;
    sb.push_back(to_stage(v));
    #1;
    chk("imm_src_d", 32'(imm_src_d), 32'(v.imm));
    chk("illegal_d", 32'(illegal_d), 32'(v.ill));
    @(posedge clk);
    popped = sb.pop_front();
    if (r) begin
      pe = '0; pm = '0; pw = '0; trap = 1'b0;
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap = trap | (pe.v & pe.ill);
`endif
      pw = pm;
      if (st && !fl) pm = '0;
      else begin
        pm = pe;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (pe.ill) pm.v = 1'b0;
`endif
      end
      if (fl) pe = '0;
      else if (!st) pe = popped;
    end
    #1;
    chk("e_stage", 32'({valid_e, alu_control_e, alu_src_e, branch_e, jump_e, branch_fn3_e}),
        32'({pe.v, pe.alu, pe.asrc, pe.br, pe.jmp, pe.bf}));
    chk("m_stage", 32'({valid_m, mem_write_m, result_src_m, reg_write_m}),
        32'({pm.v, pm.mw, pm.res, pm.rw}));
    chk("w_stage", 32'({valid_w, result_src_w, reg_write_w}), 32'({pw.v, pw.res, pw.rw}));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_e", 32'(illegal_e), 32'(pe.ill));
    chk("trap_sticky", 32'(trap_sticky), 32'(trap));
`endif
  endtask

  initial begin
    //            op          fn3     f7 vld imm    ill alu asrc br jmp mw res    rw
    tbl[0]  = mk(7'b0110011, 3'b000, 0, 1, 3'b000, 0, 0,  0,  0, 0,  0, 2'b00, 1); // add
    tbl[1]  = mk(7'b0110011, 3'b000, 1, 1, 3'b000, 0, 1,  0,  0, 0,  0, 2'b00, 1); // sub
    tbl[2]  = mk(7'b0000011, 3'b010, 0, 1, 3'b000, 0, 0,  1,  0, 0,  0, 2'b01, 1); // lw
    tbl[3]  = mk(7'b0100011, 3'b010, 0, 1, 3'b001, 0, 0,  1,  0, 0,  1, 2'b00, 0); // sw
    tbl[4]  = mk(7'b0010011, 3'b000, 1, 1, 3'b000, 0, 0,  1,  0, 0,  0, 2'b00, 1); // addi f7=1
    tbl[5]  = mk(7'b0010011, 3'b101, 1, 1, 3'b000, 0, 8,  1,  0, 0,  0, 2'b00, 1); // srai
    tbl[6]  = mk(7'b0110111, 3'b000, 0, 1, 3'b100, 0, 10, 1,  0, 0,  0, 2'b00, 1); // lui
    tbl[7]  = mk(7'b0110011, 3'b111, 0, 1, 3'b000, 0, 2,  0,  0, 0,  0, 2'b00, 1); // and
    tbl[8]  = mk(7'b0110011, 3'b110, 0, 1, 3'b000, 0, 3,  0,  0, 0,  0, 2'b00, 1); // or
    tbl[9]  = mk(7'b0110011, 3'b100, 0, 1, 3'b000, 0, 4,  0,  0, 0,  0, 2'b00, 1); // xor
    tbl[10] = mk(7'b0110011, 3'b010, 0, 1, 3'b000, 0, 5,  0,  0, 0,  0, 2'b00, 1); // slt
    tbl[11] = mk(7'b0110011, 3'b001, 0, 1, 3'b000, 0, 6,  0,  0, 0,  0, 2'b00, 1); // sll
    tbl[12] = mk(7'b0110011, 3'b101, 0, 1, 3'b000, 0, 7,  0,  0, 0,  0, 2'b00, 1); // srl
    tbl[13] = mk(7'b0110011, 3'b011, 0, 1, 3'b000, 0, 9,  0,  0, 0,  0, 2'b00, 1); // sltu
    tbl[14] = mk(7'b1100011, 3'b000, 0, 1, 3'b010, 0, 1,  0,  1, 0,  0, 2'b00, 0); // beq
    tbl[15] = mk(7'b1101111, 3'b000, 0, 1, 3'b011, 0, 0,  0,  0, 1,  0, 2'b10, 1); // jal
    tbl[16] = mk(7'b0110011, 3'b000, 0, 0, 3'b000, 0, 0,  0,  0, 0,  0, 2'b00, 1); // invalid slot
    tbl[17] = mk(7'b1111111, 3'b000, 0, 1, 3'b000, 1, 0,  0,  0, 0,  0, 2'b00, 0); // illegal
    tbl[18] = mk(7'b1100011, 3'b001, 0, 1, 3'b010, 0, 1,  0,  1, 0,  0, 2'b00, 0); // bne
    v_add = tbl[0]; v_lw = tbl[2]; v_sw = tbl[3]; v_beq = tbl[14]; v_jal = tbl[15];
    v_nop = mk(7'b0000000, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 0);

    // Reset for two cycles; decode output still tracks op_d.
    step(v_lw, 0, 0, 1);
    step(v_sw, 0, 0, 1);

    for (int i = 0; i < 19; i++) step(tbl[i], 0, 0, 0);
    for (int i = 0; i < 4; i++) step(v_nop, 0, 0, 0);

    // Branch held in E for two stalled cycles; M takes bubbles.
    step(v_beq, 0, 0, 0);
    step(v_add, 1, 0, 0);
    step(v_add, 1, 0, 0);
    step(v_add, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(v_nop, 0, 0, 0);

    // Flush outranks stall: jal in D is dropped, add already in E drains.
    step(v_add, 0, 0, 0);
    step(v_jal, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(v_nop, 0, 0, 0);

    // Reset applied mid-stream clears every stage.
    step(v_lw, 0, 0, 0);
    step(v_sw, 0, 0, 0);
    step(v_add, 0, 0, 1);
    step(v_add, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(v_nop, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
